// File: rtl/text_screen_buffer_pkg.sv
// Shared types and constants for the text screen buffer: controller state
// encoding, display read-source select, control-character codes and the
// default fill (blank) character.
package text_screen_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_SCROLL_COPY,
    ST_SCROLL_FILL
  } state_t;

  // Source of the registered display read data.
  typedef enum logic [1:0] {
    RD_ZERO,
    RD_FILL,
    RD_RAM
  } rd_sel_t;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  localparam logic [7:0] DEFAULT_FILL = 8'h20;

endpackage

// File: rtl/text_screen_buffer_if.sv
// Character-in handshake, display read port and status of the text screen
// buffer. The master drives characters and read addresses; the slave is the
// buffer itself.
interface text_screen_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic [ADDR_W-1:0] cursor;

  modport master (
    output rx_data, rx_valid, rd_addr,
    input  rx_ready, rd_data, busy, cursor
  );

  modport slave (
    input  rx_data, rx_valid, rd_addr,
    output rx_ready, rd_data, busy, cursor
  );

endinterface

// File: rtl/text_screen_buffer_dp_ram_sync.sv
// Generic simple dual-port RAM: one synchronous write port and one registered
// read port. A read and a write to the same address in the same cycle return
// the old contents (read-before-write).
module dp_ram_sync #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // NOTE: the array has no reset so it maps onto block RAM; the controller
  // initialises it by sweeping the clear state after every reset.
  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read port; both non-blocking, so a same-cycle
  // read of the written cell sees the previous contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_screen_buffer.sv
// Text screen buffer: stores received characters at a cursor in a ROWS x COLS
// grid, scrolls up one row when the grid fills, and serves a registered
// display read port. Reset clears the grid to FILL one cell per cycle.
// Optional build macro TEXT_SCREEN_CTRL_EN: interpret LF, CR, BS and FF
// instead of storing them.
module text_screen_buffer
  import text_screen_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                COLS   = 32,
  parameter int                ROWS   = 8,
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(DEFAULT_FILL)
) (
  input logic                 clk,
  input logic                 reset,
  text_screen_buffer_if.slave bus
);

  localparam int DEPTH  = COLS * ROWS;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(DEPTH - COLS);
  localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'(DEPTH - COLS);
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(COLS - 1);

  state_t            state, state_nxt;
  rd_sel_t           rd_sel, rd_sel_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;     // clear / scroll sweep index
  logic [ADDR_W-1:0] cur, cur_nxt;     // next cell to write

  logic              ready;
  logic              accept;
  logic              do_store;
  logic              rd_in_range;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] ram_q;

  assign ready  = (state == ST_IDLE);
  assign accept = bus.rx_valid && ready;

  // Addresses past the grid read as blank; a grid that fills the whole
  // address space has no such addresses.
  if (DEPTH == (1 << ADDR_W)) begin : g_full_range
    assign rd_in_range = 1'b1;
  end else begin : g_part_range
    assign rd_in_range = (int'(bus.rd_addr) < DEPTH);
  end

`ifdef TEXT_SCREEN_CTRL_EN
  logic [ADDR_W-1:0] row_start;
  assign row_start = cur - (cur % COL_STEP);
`endif

  // Single shared RAM: the read port serves the display when idle and the
  // scroll source row while scrolling.
  dp_ram_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // Controller state, sweep index, cursor and read-source select.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_CLEAR;
      idx    <= '0;
      cur    <= '0;
      rd_sel <= RD_ZERO;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cur    <= cur_nxt;
      rd_sel <= rd_sel_nxt;
    end
  end

  // Next-state logic and RAM port control for clear, idle and scroll.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would infer a latch.
    state_nxt  = state;
    idx_nxt    = idx;
    cur_nxt    = cur;
    rd_sel_nxt = RD_FILL;
    we         = 1'b0;
    waddr      = idx;
    wdata      = FILL;
    raddr      = '0;
    do_store   = 1'b0;

    case (state)
      ST_CLEAR: begin
        we = 1'b1;
        if (idx == LAST_CELL) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
          cur_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end

      ST_IDLE: begin
        raddr      = rd_in_range ? bus.rd_addr : '0;
        rd_sel_nxt = rd_in_range ? RD_RAM : RD_FILL;
        if (accept) begin
`ifdef TEXT_SCREEN_CTRL_EN
          if (bus.rx_data == DATA_W'(CH_LF)) begin
            if (cur >= LAST_ROW) begin
              cur_nxt   = LAST_ROW;
              state_nxt = ST_SCROLL_COPY;
              idx_nxt   = '0;
            end else begin
              cur_nxt = row_start + COL_STEP;
            end
          end else if (bus.rx_data == DATA_W'(CH_CR)) begin
            cur_nxt = row_start;
          end else if (bus.rx_data == DATA_W'(CH_BS)) begin
            if (cur != '0) begin
              cur_nxt = cur - 1'b1;
              we      = 1'b1;
              waddr   = cur - 1'b1;
              wdata   = FILL;
            end
          end else if (bus.rx_data == DATA_W'(CH_FF)) begin
            state_nxt = ST_CLEAR;
            idx_nxt   = '0;
            cur_nxt   = '0;
          end else begin
            do_store = 1'b1;
          end
`else
          do_store = 1'b1;
`endif
          if (do_store) begin
            we    = 1'b1;
            waddr = cur;
            wdata = bus.rx_data;
            if (cur == LAST_CELL) begin
              cur_nxt   = LAST_ROW;
              state_nxt = ST_SCROLL_COPY;
              idx_nxt   = '0;
            end else begin
              cur_nxt = cur + 1'b1;
            end
          end
        end
      end

      // Read cell idx+COLS, write it to idx-1 a cycle later when it returns.
      ST_SCROLL_COPY: begin
        if (idx != COPY_LAST) begin
          raddr = idx + COL_STEP;
        end
        if (idx != '0) begin
          we    = 1'b1;
          waddr = idx - 1'b1;
          wdata = ram_q;
        end
        if (idx == COPY_LAST) begin
          state_nxt = ST_SCROLL_FILL;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end

      ST_SCROLL_FILL: begin
        we    = 1'b1;
        waddr = LAST_ROW + idx;
        if (idx == FILL_LAST) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  assign bus.rx_ready = ready;
  assign bus.busy     = !ready;
  assign bus.cursor   = cur;
  assign bus.rd_data  = (rd_sel == RD_RAM)  ? ram_q :
                        (rd_sel == RD_FILL) ? FILL  : '0;

endmodule

// File: doc/text_screen_buffer.md
Name: text_screen_buffer

Overview:
- Parametrised character store for the serial-terminal display path; successor to the fixed 256-byte receive store.
- Accepts received characters over a valid/ready handshake and writes each one at a cursor into a ROWS x COLS grid.
- Scrolls the grid up one row when the grid is full. The display scanner reads cells through a registered read port.
- Adds configurable geometry, a fill character, an explicit handshake, an exposed cursor, and optional control-character handling.

Parameters:
DATA_W, 8, character width in bits
COLS, 32, characters per row (>=2)
ROWS, 8, rows in the grid (>=2)
FILL, 8'h20, value written by clear and used for the scroll-in row (DATA_W bits)
Derived localparams: DEPTH=COLS*ROWS, ADDR_W=$clog2(DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; forces the CLEAR state
rx_data  in  DATA_W  received character
rx_valid  in  1  rx_data valid
rx_ready  out  1  block accepts a character this cycle
rd_addr  in  ADDR_W  display read address (row*COLS+col)
rd_data  out  DATA_W  cell contents, registered, 1-cycle latency
busy  out  1  clear or scroll in progress
cursor  out  ADDR_W  next write cell

Behaviour:
- States: CLEAR, IDLE, SCROLL_COPY, SCROLL_FILL.
- Reset (async assert, sync release) values:
  - state=CLEAR, clear index=0, cursor=0, rd_data=0.
  - rx_ready=0, busy=1.
  - Reset mid-scroll or mid-clear abandons the operation and restarts the clear from cell 0.
- CLEAR:
  - Writes FILL to cell i, i=0..DEPTH-1, one cell per cycle (DEPTH cycles).
  - Then goes to IDLE with cursor=0.
- IDLE:
  - rx_ready=1 and busy=0 (both combinational on state).
  - An accept (rx_valid&&rx_ready) writes rx_data to mem[cursor] in the same cycle; back-to-back accepts are allowed, one per cycle.
  - Cursor after a write:
    - cursor<DEPTH-1: cursor+1.
    - cursor==DEPTH-1: cursor becomes DEPTH-COLS and the state goes to SCROLL_COPY.
  - rx_valid with no accept is held by the sender; the data is not dropped.
- SCROLL_COPY:
  - Copies mem[a+COLS] to mem[a] for a=0..DEPTH-COLS-1.
  - Uses the internal read port with a 1-cycle pipeline, so it takes DEPTH-COLS+1 cycles.
- SCROLL_FILL:
  - Writes FILL to cells DEPTH-COLS..DEPTH-1 (COLS cycles), then goes to IDLE.
- Total scroll time: DEPTH+1 cycles. rx_ready=0 and busy=1 throughout.
- Display read port:
  - rd_data <= mem[rd_addr] each cycle in IDLE.
  - While busy, rd_data <= FILL (the display shows blanks during a transition).
  - A read and a write to the same cell in the same cycle return the old contents (read-before-write).
- Cells are never written outside 0..DEPTH-1. rd_addr>=DEPTH returns FILL.

Optional Feature:
- Macro: TEXT_SCREEN_CTRL_EN.
- When defined, these accepted characters are interpreted and not stored:
  - 0x0A (LF): cursor moves to the start of the next row. On the last row it triggers a scroll and cursor becomes DEPTH-COLS.
  - 0x0D (CR): cursor moves to the start of the current row.
  - 0x08 (BS): if cursor>0, cursor-1 and FILL is written at the new cursor; if cursor==0, no effect.
  - 0x0C (FF): enters CLEAR and sets cursor=0.
- All other values are stored normally. Each control character is accepted in one cycle, like a printable one.
- When undefined, every value (control codes included) is stored as data.

Decomposition:
- Shared package text_screen_pkg holds:
  - the state enum;
  - constants CH_LF=8'h0A, CH_CR=8'h0D, CH_BS=8'h08, CH_FF=8'h0C;
  - the default FILL.
- One sub-module: dp_ram_sync.
  - Generic, parametrised on DATA_W and DEPTH.
  - One synchronous write port and one synchronous registered read port, read-before-write.
- The top level muxes the read address between rd_addr and the scroll source.

Test Plan:
- Reset then wait DEPTH cycles: busy=1 for exactly DEPTH cycles, then rx_ready=1, cursor=0, and every rd_addr reads 0x20.
- Use COLS=4, ROWS=2. Send 'A'..'G' with rx_valid held high: one accept per cycle, cursor=7, cell 6 reads 'G', cell 7 reads 0x20.
- Same config, send 'A'..'H': after 'H', busy=1 for 9 cycles and rx_ready=0; then cells 0..3='E','F','G','H', cells 4..7=0x20, cursor=4.
- Same config, assert reset on the 3rd scroll cycle: busy stays 1 for 8 cycles of clear, then all cells=0x20 and cursor=0.
- rd_data latency: set rd_addr=2 after writing 'X' there; rd_data='X' on the next edge. While busy, rd_data=0x20.
- With TEXT_SCREEN_CTRL_EN and COLS=4, ROWS=2:
  - 'A',0x0A,'B' gives cell 0='A', cell 4='B', cursor=5.
  - Then 0x08 gives cursor=4 and cell 4=0x20.
  - Without the macro, the same stream stores 0x0A in cell 1.
